// File: rtl/i2c_slave_ctrl.sv
// i2c_slave_ctrl: 7-bit-address I2C target with oversampled SCL/SDA.
// Ports: clk, rst_n, scl_in, sda_in -> sda_oe, rx_data/rx_valid,
//   tx_data/tx_req read handshake, addressed, rw, start_det, stop_det.
module i2c_slave_ctrl #(
   parameter logic [6:0] SLAVE_ADDR  = 7'h50,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_req,
   output logic       addressed,
   output logic       rw,
   output logic       start_det,
   output logic       stop_det
);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      WR_DATA,
      WR_ACK,
      RD_DATA,
      RD_ACK,
      WAIT_STOP
   } state_t;

   state_t state;

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_d;
   logic                   sda_d;
   logic                   scl_s;
   logic                   sda_s;

   logic scl_rise;
   logic scl_fall;
   logic start_ev;
   logic stop_ev;

   logic [3:0] cnt;
   logic [7:0] shift;
   logic [7:0] shift_in;

   // Synchronizers reset to the idle bus level (both lines high) so
   // reset release cannot fabricate an edge or START/STOP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
         scl_d    <= scl_sync[SYNC_STAGES-1];
         sda_d    <= sda_sync[SYNC_STAGES-1];
      end
   end

   assign scl_s = scl_sync[SYNC_STAGES-1];
   assign sda_s = sda_sync[SYNC_STAGES-1];

   assign scl_rise = scl_s & ~scl_d;
   assign scl_fall = ~scl_s & scl_d;

   // START/STOP need SCL stable high across both samples.
   assign start_ev = scl_s & scl_d & sda_d & ~sda_s;
   assign stop_ev  = scl_s & scl_d & ~sda_d & sda_s;

   assign shift_in = {shift[6:0], sda_s};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         shift     <= 8'd0;
         sda_oe    <= 1'b0;
         rx_data   <= 8'd0;
         rx_valid  <= 1'b0;
         tx_req    <= 1'b0;
         addressed <= 1'b0;
         rw        <= 1'b0;
         start_det <= 1'b0;
         stop_det  <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         tx_req    <= 1'b0;
         start_det <= 1'b0;
         stop_det  <= 1'b0;

         if (start_ev) begin
            start_det <= 1'b1;
            state     <= ADDR;
            cnt       <= 4'd0;
            sda_oe    <= 1'b0;
            addressed <= 1'b0;
         end else if (stop_ev) begin
            stop_det  <= 1'b1;
            state     <= IDLE;
            cnt       <= 4'd0;
            sda_oe    <= 1'b0;
            addressed <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
               end

               // cnt==8 marks "address matched, ACK pending
               // on the next falling edge".
               ADDR: begin
                  if (scl_rise) begin
                     shift <= shift_in;
                     if (cnt == 4'd7) begin
                        if (shift[6:0] == SLAVE_ADDR) begin
                           rw  <= sda_s;
                           cnt <= 4'd8;
                        end else begin
                           state <= WAIT_STOP;
                           cnt   <= 4'd0;
                        end
                     end else begin
                        cnt <= cnt + 4'd1;
                     end
                  end else if (scl_fall && cnt == 4'd8) begin
                     sda_oe    <= 1'b1;
                     addressed <= 1'b1;
                     state     <= ADDR_ACK;
                     cnt       <= 4'd0;
                  end
               end

               ADDR_ACK: begin
                  if (scl_rise) begin
                     tx_req <= rw;
                  end else if (scl_fall) begin
                     cnt <= 4'd0;
                     if (rw) begin
                        shift  <= tx_data;
                        sda_oe <= ~tx_data[7];
                        state  <= RD_DATA;
                     end else begin
                        sda_oe <= 1'b0;
                        state  <= WR_DATA;
                     end
                  end
               end

               WR_DATA: begin
                  if (scl_rise) begin
                     shift <= shift_in;
                     cnt   <= cnt + 4'd1;
                     if (cnt == 4'd7) begin
                        rx_data  <= shift_in;
                        rx_valid <= 1'b1;
                     end
                  end else if (scl_fall && cnt == 4'd8) begin
                     sda_oe <= 1'b1;
                     state  <= WR_ACK;
                     cnt    <= 4'd0;
                  end
               end

               WR_ACK: begin
                  if (scl_fall) begin
                     sda_oe <= 1'b0;
                     state  <= WR_DATA;
                     cnt    <= 4'd0;
                  end
               end

               // MSB is already on the bus at entry; each fall
               // advances one bit, the 8th fall releases SDA.
               RD_DATA: begin
                  if (scl_fall) begin
                     if (cnt == 4'd7) begin
                        sda_oe <= 1'b0;
                        state  <= RD_ACK;
                        cnt    <= 4'd0;
                     end else begin
                        shift  <= {shift[6:0], 1'b0};
                        sda_oe <= ~shift[6];
                        cnt    <= cnt + 4'd1;
                     end
                  end
               end

               // cnt==1 records that the master ACKed, so the
               // next fall loads the fresh byte.
               RD_ACK: begin
                  if (scl_rise) begin
                     if (!sda_s) begin
                        tx_req <= 1'b1;
                        cnt    <= 4'd1;
                     end else begin
                        state     <= WAIT_STOP;
                        addressed <= 1'b0;
                     end
                  end else if (scl_fall && cnt == 4'd1) begin
                     shift  <= tx_data;
                     sda_oe <= ~tx_data[7];
                     state  <= RD_DATA;
                     cnt    <= 4'd0;
                  end
               end

               WAIT_STOP: begin
                  sda_oe <= 1'b0;
               end

               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// tb_i2c_slave_ctrl: bus-level master model driving i2c_slave_ctrl
// with directed and randomized transactions.
module tb_i2c_slave_ctrl;

   localparam logic [6:0] SA = 7'h50;
   localparam int         H  = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl_in;
   logic       sda_in;
   logic       sda_oe;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data = 8'h00;
   logic       tx_req;
   logic       addressed;
   logic       rw;
   logic       start_det;
   logic       stop_det;

   logic m_scl = 1'b1;
   logic m_sda = 1'b1;

   assign scl_in = m_scl;
   assign sda_in = m_sda & ~sda_oe;

   i2c_slave_ctrl #(.SLAVE_ADDR(SA), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .scl_in    (scl_in),
      .sda_in    (sda_in),
      .sda_oe    (sda_oe),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .tx_data   (tx_data),
      .tx_req    (tx_req),
      .addressed (addressed),
      .rw        (rw),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int n_txr = 0;
   int n_start = 0;
   int n_stop = 0;
   int n_viol = 0;
   logic oe_q = 1'b0;
   logic [7:0] rx_log[$];
   logic [7:0] tx_q[$];

   always @(negedge clk) begin
      if (rx_valid) rx_log.push_back(rx_data);
      if (tx_req) begin
         n_txr++;
         if (tx_q.size() > 0) tx_data = tx_q.pop_front();
      end
      if (start_det) n_start++;
      if (stop_det) n_stop++;
      if (sda_oe && !oe_q && m_scl) n_viol++;
      oe_q = sda_oe;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      m_sda = 1'b1;
      wait_clk(H / 2);
      m_scl = 1'b1;
      wait_clk(H);
      m_sda = 1'b0;
      wait_clk(H);
      m_scl = 1'b0;
      wait_clk(H / 2);
   endtask

   task automatic bus_stop();
      m_sda = 1'b0;
      wait_clk(H / 2);
      m_scl = 1'b1;
      wait_clk(H);
      m_sda = 1'b1;
      wait_clk(H);
   endtask

   task automatic clk_bit(input logic b, output logic s);
      m_sda = b;
      wait_clk(H / 2);
      m_scl = 1'b1;
      wait_clk(H / 2);
      s = sda_in;
      wait_clk(H / 2);
      m_scl = 1'b0;
      wait_clk(H / 2);
   endtask

   task automatic wr_byte(input logic [7:0] d, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
      clk_bit(1'b1, s);
      ack = ~s;
   endtask

   task automatic rd_byte(input logic m_ack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b1, s);
         d[i] = s;
      end
      clk_bit(~m_ack, s);
   endtask

   initial begin
      logic       ack;
      logic       s;
      logic [7:0] d;
      int         t0;
      int         s0;

      rst_n = 1'b0;
      wait_clk(3);
      check("reset_outs",
            {sda_oe, rx_valid, tx_req, addressed, rw,
             start_det, stop_det, rx_data}, 0);
      rst_n = 1'b1;
      wait_clk(4);

      // single byte write
      rx_log.delete();
      s0 = n_stop;
      bus_start();
      wr_byte({SA, 1'b0}, ack);
      check("t1_addr_ack", ack, 1);
      check("t1_addressed", addressed, 1);
      wr_byte(8'hA5, ack);
      check("t1_data_ack", ack, 1);
      bus_stop();
      check("t1_rx_count", rx_log.size(), 1);
      check("t1_rx_byte", rx_log[0], 8'hA5);
      check("t1_rx_data", rx_data, 8'hA5);
      check("t1_stop_cnt", n_stop - s0, 1);
      check("t1_addressed_end", addressed, 0);

      // wrong address
      rx_log.delete();
      bus_start();
      wr_byte({7'h51, 1'b0}, ack);
      check("t2_addr_nack", ack, 0);
      check("t2_addressed", addressed, 0);
      wr_byte(8'h3F, ack);
      check("t2_data_nack", ack, 0);
      check("t2_oe", sda_oe, 0);
      bus_stop();
      check("t2_rx_count", rx_log.size(), 0);

      // two-byte read, ACK then NACK
      t0 = n_txr;
      tx_q.push_back(8'h3C);
      tx_q.push_back(8'hC3);
      bus_start();
      wr_byte({SA, 1'b1}, ack);
      check("t3_addr_ack", ack, 1);
      check("t3_rw", rw, 1);
      rd_byte(1'b1, d);
      check("t3_byte0", d, 8'h3C);
      rd_byte(1'b0, d);
      check("t3_byte1", d, 8'hC3);
      check("t3_oe_after_nack", sda_oe, 0);
      check("t3_addressed", addressed, 0);
      check("t3_tx_req_cnt", n_txr - t0, 2);
      bus_stop();

      // write then repeated START read
      rx_log.delete();
      s0 = n_start;
      t0 = n_txr;
      bus_start();
      wr_byte({SA, 1'b0}, ack);
      check("t4_w_ack", ack, 1);
      check("t4_rw_w", rw, 0);
      wr_byte(8'h12, ack);
      check("t4_d_ack", ack, 1);
      tx_q.push_back(8'h5A);
      bus_start();
      wr_byte({SA, 1'b1}, ack);
      check("t4_r_ack", ack, 1);
      check("t4_rw_r", rw, 1);
      rd_byte(1'b0, d);
      check("t4_rd_byte", d, 8'h5A);
      bus_stop();
      check("t4_start_cnt", n_start - s0, 2);
      check("t4_tx_req_cnt", n_txr - t0, 1);
      check("t4_rx_count", rx_log.size(), 1);
      check("t4_rx_byte", rx_log[0], 8'h12);

      // STOP after four data bits
      rx_log.delete();
      bus_start();
      wr_byte({SA, 1'b0}, ack);
      check("t5_addr_ack", ack, 1);
      for (int i = 0; i < 4; i++) clk_bit(i[0], s);
      bus_stop();
      check("t5_rx_count", rx_log.size(), 0);
      check("t5_oe", sda_oe, 0);
      check("t5_addressed", addressed, 0);
      bus_start();
      wr_byte({SA, 1'b0}, ack);
      check("t5_re_addr_ack", ack, 1);
      wr_byte(8'h7E, ack);
      check("t5_re_data_ack", ack, 1);
      bus_stop();
      check("t5_re_rx_count", rx_log.size(), 1);
      check("t5_re_rx_byte", rx_log[0], 8'h7E);

      // reset while the address ACK is driven
      d = {SA, 1'b0};
      bus_start();
      for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
      m_sda = 1'b1;
      wait_clk(H / 2);
      m_scl = 1'b1;
      wait_clk(2);
      check("t6_oe_before", sda_oe, 1);
      rst_n = 1'b0;
      #1;
      check("t6_outs_in_rst",
            {sda_oe, rx_valid, tx_req, addressed, rw,
             start_det, stop_det, rx_data}, 0);
      wait_clk(3);
      m_scl = 1'b0;
      wait_clk(2);
      rst_n = 1'b1;
      wait_clk(H);
      check("t6_oe_after", sda_oe, 0);
      bus_stop();
      rx_log.delete();
      bus_start();
      wr_byte({SA, 1'b0}, ack);
      check("t6_addr_ack", ack, 1);
      wr_byte(8'hE1, ack);
      check("t6_data_ack", ack, 1);
      bus_stop();
      check("t6_rx_count", rx_log.size(), 1);
      check("t6_rx_byte", rx_log[0], 8'hE1);

      // randomized transactions against a byte-level model
      for (int t = 0; t < 16; t++) begin
         logic [6:0] a;
         logic       r;
         logic       match;
         int         n;
         logic [7:0] exp_b[$];

         a = ($urandom_range(0, 1) == 1) ? SA : 7'($urandom_range(0, 127));
         r = 1'($urandom_range(0, 1));
         n = $urandom_range(1, 4);
         match = (a == SA);
         exp_b.delete();
         rx_log.delete();
         t0 = n_txr;
         if (match && r) begin
            for (int i = 0; i < n; i++) begin
               d = 8'($urandom);
               exp_b.push_back(d);
               tx_q.push_back(d);
            end
         end
         bus_start();
         wr_byte({a, r}, ack);
         check("rnd_addr_ack", ack, match);
         if (match && !r) begin
            for (int i = 0; i < n; i++) begin
               d = 8'($urandom);
               exp_b.push_back(d);
               wr_byte(d, ack);
               check("rnd_wr_ack", ack, 1);
            end
         end
         if (match && r) begin
            for (int i = 0; i < n; i++) begin
               rd_byte(i != n - 1, d);
               check("rnd_rd_byte", d, exp_b[i]);
            end
            check("rnd_rd_oe", sda_oe, 0);
         end
         bus_stop();
         check("rnd_tx_req_cnt", n_txr - t0, (match && r) ? n : 0);
         check("rnd_rx_count", rx_log.size(), (match && !r) ? n : 0);
         if (match && !r) begin
            for (int i = 0; i < n; i++)
               check("rnd_rx_byte", rx_log[i], exp_b[i]);
         end
         check("rnd_addressed_end", addressed, 0);
      end

      check("oe_rise_scl_high", n_viol, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/i2c_slave_ctrl.md
Name: i2c_slave_ctrl

Overview:
7-bit-address I2C target (responder) for the far end of the bus driven by our I2C master and its clock divider.
Oversamples SCL/SDA on the system clock, detects START/STOP, and matches its address. Accepts write bytes and presents them on a one-cycle strobe; requests read bytes from the user side through a request/data handshake.
SDA is driven open-drain through an output-enable; SCL is input only, with no clock stretching.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit bus address this target responds to
SYNC_STAGES, 2, synchronizer flops on scl_in/sda_in (minimum 2)

Ports:
clk  input  1  system clock; rising edge only
rst_n  input  1  asynchronous active-low reset
scl_in  input  1  raw SCL pin level
sda_in  input  1  raw SDA pin level
sda_oe  output  1  1 = pull SDA low; 0 = release (pad ties output data to 0)
rx_data  output  8  last byte written by master; held until next byte
rx_valid  output  1  one-cycle strobe, rx_data updated
tx_data  input  8  byte to return on a read
tx_req  output  1  one-cycle strobe, user must present next tx_data
addressed  output  1  high from address ACK until STOP/START/NACK-end
rw  output  1  R/W bit of current transaction (1 = read)
start_det  output  1  one-cycle strobe on START or repeated START
stop_det  output  1  one-cycle strobe on STOP

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; bit counter 0; shift register 0.
- Input path: SYNC_STAGES flops per line, plus one delayed copy for edge detection. Internal events lag the pins by SYNC_STAGES+1 clk. Requirement: SCL high and low phases each ≥ 4 clk.
- Events, on synchronized signals:
  - scl_rise, scl_fall from SCL edges.
  - START: SDA falls while SCL high.
  - STOP: SDA rises while SCL high.
  - START/STOP take priority over any data-bit action in the same cycle.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- START from any state (including repeated START): start_det=1, state→ADDR, bit count 0, sda_oe 0, addressed 0.
- STOP from any state: stop_det=1, state→IDLE, sda_oe 0, addressed 0.
- ADDR:
  - Shift SDA in MSB-first on each scl_rise.
  - After the 8th bit: compare [7:1] with SLAVE_ADDR.
    - Match: latch rw=bit0; set sda_oe=1 on the next scl_fall; →ADDR_ACK.
    - Mismatch: →WAIT_STOP, never drive SDA.
- ADDR_ACK: addressed=1 at entry.
  - rw=0: release sda_oe on the scl_fall ending the ACK clock; →WR_DATA.
  - rw=1: tx_req pulses on the ACK scl_rise. tx_data is sampled on the following scl_fall, which also drives the MSB; →RD_DATA.
- WR_DATA:
  - Shift 8 bits on scl_rise.
  - On the 8th rise: rx_data←shifted byte; rx_valid pulses in that same cycle.
  - Next scl_fall: sda_oe=1; →WR_ACK.
  - Every written byte is ACKed.
- WR_ACK: release sda_oe on the closing scl_fall; →WR_DATA, counter 0.
- RD_DATA:
  - sda_oe = ~shift[7].
  - Shift left on each scl_fall after the first bit.
  - After the 8th bit's scl_fall: sda_oe=0; →RD_ACK.
- RD_ACK: sample SDA on scl_rise.
  - 0 (ACK): pulse tx_req; load the new byte on the next scl_fall; →RD_DATA.
  - 1 (NACK): →WAIT_STOP; addressed=0.
- WAIT_STOP: ignore SCL and keep sda_oe=0 until START or STOP.
- sda_oe changes only on scl_fall, or falls to 0 on START/STOP/reset. It never changes while SCL is high.
- Counter is 4 bits and wraps back to 0 at each byte boundary. No overflow is possible.
- Reset mid-transfer: SDA is released immediately (asynchronously), and the block ignores the bus until the next START.

Test Plan:
- START, addr 0x50+W, data 0xA5, STOP → ACK low on 9th clock of each byte; rx_data=0xA5 with a single rx_valid pulse; stop_det once; addressed 1→0.
- START, addr 0x51+W → no ACK (sda_oe stays 0); no rx_valid; state WAIT_STOP until STOP.
- START, 0x50+R, tx_data 0x3C then 0xC3, master ACK then NACK, STOP → SDA bits 00111100, 11000011; tx_req pulses exactly twice; sda_oe 0 after NACK.
- Write 0x12, then repeated START 0x50+R → start_det twice; rw flips 0→1; read byte taken from tx_data; no spurious rx_valid.
- STOP injected after 4 data bits of a write → IDLE; no rx_valid; sda_oe 0; next full transaction works.
- rst_n low while sda_oe=1 during an ACK → sda_oe 0 immediately; all outputs 0; the following START/address is accepted normally.
